fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
Shares one fpu instance between NREQ requesters, using round-robin arbitration.
- Latches the winning requester's four operands and drives the fpu en/fi handshake.
- Captures result g and returns it to the winner with a one-cycle ack.
- A watchdog aborts any operation whose fi never arrives, so a stuck fpu cannot hang the requesters.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width (IEEE-754 single)
TIMEOUT, 255, max cycles in RUN waiting for fpu_fi before abort (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  per-requester request level; held with operands until own ack
op_a  input  NREQ*W  operand a, requester i at [i*W +: W]; op_b, op_c, op_d identical layout
ack  output  NREQ  one-cycle pulse to the served requester
res  output  W  result, valid only in the ack cycle
err  output  1  high in the ack cycle if the operation timed out
busy  output  1  high whenever state != IDLE
fpu_en  output  1  to fpu en
fpu_a, fpu_b, fpu_c, fpu_d  output  W  to fpu operands, registered
fpu_fi  input  1  from fpu fi (finish)
fpu_g  input  W  from fpu g (result)

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, ack=0, res=0, err=0, busy=0, fpu_en=0, fpu_a..d=0, wait counter=0. Takes effect immediately, including mid-operation; the fpu sees en fall asynchronously.
- States: IDLE, RUN, RESP.
- IDLE: if req!=0 and fpu_fi==0, pick winner g:
  - g = first set bit at or after the rr pointer, wrapping modulo NREQ.
  - At the edge, latch op_x[g] into fpu_x, set fpu_en=1, store gnt=g, clear counter, go to RUN.
  - No grant while fpu_fi is still high.
- RUN: fpu_en=1, operands stable, counter increments each cycle.
  - fpu_fi sampled 1: res<=fpu_g, err<=0, go to RESP.
  - Otherwise, counter==TIMEOUT-1: res<=0, err<=1, go to RESP.
  - fi has priority when both occur in the same cycle.
- RESP (exactly 1 cycle): ack[gnt]=1, fpu_en=0, rr pointer<=(gnt+1) mod NREQ, then go to IDLE.
- fpu_en is therefore low for at least 2 cycles (RESP + IDLE) between operations.
- Latency: req high at edge k → fpu_en high after edge k. fi sampled at edge m → ack high for cycle m..m+1. Minimum request-to-ack is 2 cycles plus fpu time.
- res and err hold their value outside RESP; consumers use them only in the ack cycle.
- req dropped mid-operation (protocol violation): the operation completes and ack is still pulsed.
- A requester re-asserting req right after its ack has lowest priority if others are waiting.
- Simultaneous requests: the lowest index at or after the pointer wins. No requester waits more than NREQ-1 grants.
- Counter width is clog2(TIMEOUT+1) and it saturates (never wraps).
- Result is passed through unmodified; no arithmetic in this block.

Decomposition:
- Package fpu_ctl_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, RESP=2'd2)
  - default W=32
  - a clog2 function
- Sub-module rr_arbiter (parameter NREQ):
  - inputs req and ptr; outputs a one-hot grant and a binary index.
  - purely combinational.
- fpu_arbiter owns the FSM, the pointer, the operand muxes and the watchdog.

Test Plan:
1. Single request: req=4'b0001, op_a..d=3f800000/40000000/40400000/00000000; fpu model raises fi after 5 cycles with g=40c00000.
   → fpu_en high 1 cycle after req; ack=0001 for 1 cycle; res=40c00000; err=0.
2. All four req together from reset → grants in order 0,1,2,3, then 0 again while req stays held; fpu_en is low ≥2 cycles between grants.
3. Model never raises fi, TIMEOUT=8 → ack pulse 8 cycles after fpu_en rose; err=1, res=0; next request is served normally.
4. Reset asserted mid-RUN (fi pending) → fpu_en, ack, busy, res, err go to 0 without a clock edge; after release, pointer=0 and req=0010 is granted normally.
5. fpu_fi left high at end of RESP with req=0001 → no grant until fi falls; grant on the first IDLE cycle with fi=0.
6. Pointer at 2, req=1001 → requester 3 is granted before 0; then, with req=0001 held, 0 is granted next.

Source files
------------

// File: rtl/fpu_ctl_pkg.sv
// Shared types and helpers for the fpu sharing controller.
package fpu_ctl_pkg;

   localparam int DEF_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int p = 1; p < value; p = p << 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter
   import fpu_ctl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_idx
);

   logic          w_found;
   logic [PW-1:0] w_j;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_j = PW'((int'(i_ptr) + i) % NREQ);
         if (!w_found && i_req[w_j]) begin
            w_found     = 1'b1;
            o_gnt[w_j]  = 1'b1;
            o_idx       = w_j;
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu among NREQ requesters: round-robin grant, en/fi handshake,
// one-cycle ack with the result, and a watchdog that aborts a stuck operation.
module fpu_arbiter
   import fpu_ctl_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = DEF_W,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ*W-1:0] op_a,
   input  logic [NREQ*W-1:0] op_b,
   input  logic [NREQ*W-1:0] op_c,
   input  logic [NREQ*W-1:0] op_d,
   output logic [NREQ-1:0] ack,
   output logic [W-1:0]    res,
   output logic            err,
   output logic            busy,
   output logic            fpu_en,
   output logic [W-1:0]    fpu_a,
   output logic [W-1:0]    fpu_b,
   output logic [W-1:0]    fpu_c,
   output logic [W-1:0]    fpu_d,
   input  logic            fpu_fi,
   input  logic [W-1:0]    fpu_g
);

   localparam int PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
   localparam int CW = clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   state_t          r_state;
   state_t          w_next;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_gntIdx;
   logic [NREQ-1:0] r_gntOh;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_res;
   logic            r_err;
   logic [W-1:0]    r_fpuA;
   logic [W-1:0]    r_fpuB;
   logic [W-1:0]    r_fpuC;
   logic [W-1:0]    r_fpuD;
   logic [NREQ-1:0] w_gnt;
   logic [PW-1:0]   w_idx;
   logic            w_grant;
   logic            w_timeout;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   // A grant waits for the fpu to drop fi from the previous operation.
   assign w_grant   = (r_state == IDLE) && (req != '0) && !fpu_fi;
   assign w_timeout = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_next = RUN;
         RUN:     if (fpu_fi || w_timeout) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr    <= '0;
         r_gntIdx <= '0;
         r_gntOh  <= '0;
         r_cnt    <= '0;
         r_res    <= '0;
         r_err    <= 1'b0;
         r_fpuA   <= '0;
         r_fpuB   <= '0;
         r_fpuC   <= '0;
         r_fpuD   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_fpuA   <= op_a[w_idx*W +: W];
                  r_fpuB   <= op_b[w_idx*W +: W];
                  r_fpuC   <= op_c[w_idx*W +: W];
                  r_fpuD   <= op_d[w_idx*W +: W];
                  r_gntIdx <= w_idx;
                  r_gntOh  <= w_gnt;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               // fi wins over the watchdog when both land in the same cycle.
               if (fpu_fi) begin
                  r_res <= fpu_g;
                  r_err <= 1'b0;
               end else if (w_timeout) begin
                  r_res <= '0;
                  r_err <= 1'b1;
               end
            end
            RESP: begin
               r_ptr <= (r_gntIdx == PW'(NREQ - 1)) ? '0 : r_gntIdx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign ack    = (r_state == RESP) ? r_gntOh : '0;
   assign res    = r_res;
   assign err    = r_err;
   assign busy   = (r_state != IDLE);
   assign fpu_en = (r_state == RUN);
   assign fpu_a  = r_fpuA;
   assign fpu_b  = r_fpuB;
   assign fpu_c  = r_fpuC;
   assign fpu_d  = r_fpuD;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: behavioural fpu model plus a scoreboard
// of expected (requester, result, error) entries popped on every ack.
module tb_fpu_arbiter;

   localparam int NREQ    = 4;
   localparam int W       = 32;
   localparam int TIMEOUT = 8;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] op_a;
   logic [NREQ*W-1:0] op_b;
   logic [NREQ*W-1:0] op_c;
   logic [NREQ*W-1:0] op_d;
   logic [NREQ-1:0]   ack;
   logic [W-1:0]      res;
   logic              err;
   logic              busy;
   logic              fpu_en;
   logic [W-1:0]      fpu_a;
   logic [W-1:0]      fpu_b;
   logic [W-1:0]      fpu_c;
   logic [W-1:0]      fpu_d;
   logic              fpu_fi;
   logic [W-1:0]      fpu_g;

   int totalChecks = 0;
   int badChecks   = 0;
   exp_t sb[$];

   // fpu model controls
   int          fiDelay       = 5;
   bit          fiNever       = 1'b0;
   bit          holdFi        = 1'b0;
   bit          modelOverride = 1'b0;
   logic [31:0] overrideG     = '0;
   int          mCnt          = 0;
   logic [NREQ-1:0] holdMask  = '0;

   // monitor state for the en low-gap measurement
   bit prevEn = 1'b0;
   bit enSeen = 1'b0;
   int enGap  = 0;

   fpu_arbiter #(
      .NREQ    (NREQ),
      .W       (W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .op_a   (op_a),
      .op_b   (op_b),
      .op_c   (op_c),
      .op_d   (op_d),
      .ack    (ack),
      .res    (res),
      .err    (err),
      .busy   (busy),
      .fpu_en (fpu_en),
      .fpu_a  (fpu_a),
      .fpu_b  (fpu_b),
      .fpu_c  (fpu_c),
      .fpu_d  (fpu_d),
      .fpu_fi (fpu_fi),
      .fpu_g  (fpu_g)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalChecks++;
      if (obs !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Loads a requester's operands and queues the result the fpu model will produce for them.
   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d, input bit expTimeout);
      exp_t e;
      op_a[idx*W +: W] = a;
      op_b[idx*W +: W] = b;
      op_c[idx*W +: W] = c;
      op_d[idx*W +: W] = d;
      e.idx = idx;
      e.err = expTimeout;
      if (expTimeout)
         e.res = '0;
      else if (modelOverride)
         e.res = overrideG;
      else
         e.res = a ^ b ^ c ^ d;
      sb.push_back(e);
   endtask

   task automatic waitAcks(input int n, input int budget);
      int seen;
      int cyc;
      seen = 0;
      cyc  = 0;
      while (seen < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (ack != '0) begin
            seen++;
            req = req & ~(ack & ~holdMask);
         end
      end
      checkOutput("ackCount", 64'(seen), 64'(n));
   endtask

   // Behavioural fpu: raises fi fiDelay cycles into an operation, drops it once en falls.
   always @(posedge clk) begin
      if (fpu_en) begin
         if (!fiNever && !fpu_fi) begin
            if (mCnt + 1 >= fiDelay) begin
               fpu_fi <= 1'b1;
               fpu_g  <= modelOverride ? overrideG : (fpu_a ^ fpu_b ^ fpu_c ^ fpu_d);
            end
            mCnt <= mCnt + 1;
         end
      end else begin
         mCnt <= 0;
         if (!holdFi) fpu_fi <= 1'b0;
      end
   end

   // Scoreboard consumer and en low-gap monitor.
   always @(negedge clk) begin
      if (!rst) begin
         prevEn = 1'b0;
         enSeen = 1'b0;
         enGap  = 0;
      end else begin
         if (ack != '0) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedAck", 64'(ack), 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("ack", 64'(ack), 64'(1) << e.idx);
               checkOutput("res", 64'(res), 64'(e.res));
               checkOutput("err", 64'(err), 64'(e.err));
            end
         end
         if (fpu_en) begin
            if (!prevEn && enSeen) checkOutput("enGap>=2", (enGap >= 2) ? 64'd1 : 64'd0, 64'd1);
            enSeen = 1'b1;
            enGap  = 0;
         end else begin
            enGap++;
         end
         prevEn = fpu_en;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL globalTimeout: got expired expected finish");
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks + 1);
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int cnt;
      rst    = 1'b0;
      req    = '0;
      op_a   = '0;
      op_b   = '0;
      op_c   = '0;
      op_d   = '0;
      fpu_fi = 1'b0;
      fpu_g  = '0;

      repeat (3) @(negedge clk);
      checkOutput("rstAck",   64'(ack),    64'(0));
      checkOutput("rstRes",   64'(res),    64'(0));
      checkOutput("rstErr",   64'(err),    64'(0));
      checkOutput("rstBusy",  64'(busy),   64'(0));
      checkOutput("rstEn",    64'(fpu_en), 64'(0));
      checkOutput("rstFpuA",  64'(fpu_a),  64'(0));
      rst = 1'b1;
      @(negedge clk);

      // single request with a fixed fpu result
      modelOverride = 1'b1;
      overrideG     = 32'h40c00000;
      fiDelay       = 5;
      applyStimulus(0, 32'h3f800000, 32'h40000000, 32'h40400000, 32'h00000000, 1'b0);
      req = 4'b0001;
      @(negedge clk);
      checkOutput("t1En",   64'(fpu_en), 64'(1));
      checkOutput("t1FpuA", 64'(fpu_a),  64'(32'h3f800000));
      checkOutput("t1FpuB", 64'(fpu_b),  64'(32'h40000000));
      checkOutput("t1FpuC", 64'(fpu_c),  64'(32'h40400000));
      waitAcks(1, 40);
      @(negedge clk);
      checkOutput("t1AckOnce", 64'(ack),  64'(0));
      checkOutput("t1Idle",    64'(busy), 64'(0));
      modelOverride = 1'b0;

      // all four from reset, held: 0,1,2,3 then 0 again
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      fiDelay = 2;
      for (int i = 0; i < NREQ; i++)
         applyStimulus(i, 32'h3f800000 + 32'(i), 32'h40000000 + 32'(i << 4),
                       32'h40400000 + 32'(i << 8), 32'(i << 12), 1'b0);
      applyStimulus(0, 32'h3f800000, 32'h40000000, 32'h40400000, 32'h00000000, 1'b0);
      holdMask = 4'b1111;
      req      = 4'b1111;
      waitAcks(5, 120);
      req      = '0;
      holdMask = '0;
      repeat (3) @(negedge clk);

      // watchdog abort (pointer at 1, requester 2 served), then a normal request
      fiNever = 1'b1;
      applyStimulus(2, 32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 32'hf0f0f0f0, 1'b1);
      req = 4'b0100;
      @(negedge clk);
      checkOutput("t3En", 64'(fpu_en), 64'(1));
      cnt = 0;
      while (cnt < 30) begin
         @(negedge clk);
         cnt++;
         if (ack != '0) break;
      end
      checkOutput("t3TimeoutLatency", 64'(cnt), 64'(TIMEOUT));
      req     = '0;
      fiNever = 1'b0;
      fiDelay = 3;
      applyStimulus(1, 32'hdeadbeef, 32'h01020304, 32'h55aa55aa, 32'h00ff00ff, 1'b0);
      req = 4'b0010;
      waitAcks(1, 40);
      repeat (2) @(negedge clk);

      // asynchronous reset in the middle of RUN
      fiDelay = 20;
      req = 4'b0100;
      repeat (3) @(negedge clk);
      checkOutput("t4BusyBefore", 64'(busy), 64'(1));
      #2;
      rst = 1'b0;
      req = '0;
      #1;
      checkOutput("t4En",   64'(fpu_en), 64'(0));
      checkOutput("t4Ack",  64'(ack),    64'(0));
      checkOutput("t4Busy", 64'(busy),   64'(0));
      checkOutput("t4Res",  64'(res),    64'(0));
      checkOutput("t4Err",  64'(err),    64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      fiDelay = 2;
      applyStimulus(1, 32'hcafef00d, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
      applyStimulus(3, 32'h0badf00d, 32'h44444444, 32'h55555555, 32'h66666666, 1'b0);
      req = 4'b1010;
      waitAcks(2, 60);
      repeat (2) @(negedge clk);

      // fi held high after RESP blocks the next grant
      holdFi = 1'b1;
      applyStimulus(0, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 1'b0);
      applyStimulus(0, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 1'b0);
      holdMask = 4'b0001;
      req      = 4'b0001;
      waitAcks(1, 40);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("t5NoGrant", 64'(fpu_en), 64'(0));
      end
      checkOutput("t5FiHeld", 64'(fpu_fi), 64'(1));
      holdFi = 1'b0;
      @(negedge clk);
      checkOutput("t5StillIdle", 64'(fpu_en), 64'(0));
      @(negedge clk);
      checkOutput("t5GrantAfterFi", 64'(fpu_en), 64'(1));
      waitAcks(1, 40);
      req      = '0;
      holdMask = '0;
      repeat (2) @(negedge clk);

      // move pointer to 2, then req=1001 serves 3 before 0
      applyStimulus(1, 32'h7f7f7f7f, 32'h80808080, 32'h13579bdf, 32'h2468ace0, 1'b0);
      req = 4'b0010;
      waitAcks(1, 40);
      repeat (2) @(negedge clk);
      applyStimulus(3, 32'h33330000, 32'h00003333, 32'h30303030, 32'h03030303, 1'b0);
      applyStimulus(0, 32'h00000001, 32'h00000010, 32'h00000100, 32'h00001000, 1'b0);
      req = 4'b1001;
      waitAcks(2, 80);

      repeat (5) @(negedge clk);
      checkOutput("sbEmpty", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
